// File: rtl/spi_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_target                                                    |
// | Brief    : SPI responder with an LSB-first addr/data frame and a register |
// |            file that on-chip logic can preload and observe.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module spi_target #(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        pclk_i,
    input  logic                        prst_i,
    input  logic                        sclk_i,
    input  logic                        cs_n_i,
    input  logic                        mosi_i,
    output logic                        miso_o,
    input  logic                        hwr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] hwr_addr_i,
    input  logic [7:0]                  hwr_data_i,
    input  logic [$clog2(NUM_REGS)-1:0] hrd_addr_i,
    output logic [7:0]                  hrd_data_o,
    output logic                        txn_done_o,
    output logic                        txn_wr_o,
    output logic [7:0]                  txn_addr_o,
    output logic                        err_o
);

    localparam int         IDX_W      = $clog2(NUM_REGS);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] shreg_q, shreg_d;
    logic       miso_q, miso_d;
    logic       done_q, done_d;
    logic       wr_q, wr_d;
    logic       err_q, err_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    logic             w_sclk_s;
    logic             w_cs_n_s;
    logic             w_mosi_s;
    logic             w_fall;
    logic             w_last;
    logic [7:0]       w_byte;
    logic             w_new_ok;
    logic             w_cur_ok;
    logic [IDX_W-1:0] w_new_idx;
    logic [IDX_W-1:0] w_cur_idx;

    assign w_sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign w_cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign w_mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign w_fall   = sclk_dly_q & ~w_sclk_s;
    assign w_last   = (count_q == 3'd7);

    // Byte as it will look once the bit arriving on this fall is merged in
    always_comb begin
        w_byte          = shift_q;
        w_byte[count_q] = w_mosi_s;
    end

    assign w_new_ok  = ({1'b0, w_byte[6:0]} < NUM_REGS_B);
    assign w_cur_ok  = ({1'b0, addr_q[6:0]} < NUM_REGS_B);
    assign w_new_idx = w_byte[IDX_W-1:0];
    assign w_cur_idx = addr_q[IDX_W-1:0];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sclk_dly_d  = w_sclk_s;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        shreg_d = shreg_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        wr_d    = wr_q;
        err_d   = 1'b0;
        addr_d  = addr_q;
        regs_d  = regs_q;

        // Host write lands first so a same-cycle SPI commit overrides it
        if (hwr_en_i) begin
            regs_d[hwr_addr_i] = hwr_data_i;
        end

        if (w_cs_n_s) begin
            state_d = S_IDLE;
            count_d = 3'd0;
            miso_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ADDR;
                    count_d = 3'd0;
                    miso_d  = 1'b1;
                end
                S_ADDR: begin
                    if (w_fall) begin
                        shift_d = w_byte;
                        count_d = count_q + 3'd1;
                        if (w_last) begin
                            addr_d  = w_byte;
                            count_d = 3'd0;
                            err_d   = ~w_new_ok;
                            if (w_byte[7]) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_RDATA;
                                shreg_d = w_new_ok ? regs_q[w_new_idx] : 8'hFF;
                                miso_d  = shreg_d[0];
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (w_fall) begin
                        shift_d = w_byte;
                        count_d = count_q + 3'd1;
                        if (w_last) begin
                            count_d = 3'd0;
                            if (w_cur_ok) begin
                                regs_d[w_cur_idx] = w_byte;
                            end
                            done_d  = 1'b1;
                            wr_d    = 1'b1;
                            state_d = S_ADDR;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_fall) begin
                        count_d = count_q + 3'd1;
                        miso_d  = shreg_q[count_d];
                        if (w_last) begin
                            count_d = 3'd0;
                            miso_d  = 1'b1;
                            done_d  = 1'b1;
                            wr_d    = 1'b0;
                            state_d = S_ADDR;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_dly_q  <= 1'b1;
            state_q     <= S_IDLE;
            count_q     <= 3'd0;
            shift_q     <= 8'h00;
            shreg_q     <= 8'hFF;
            miso_q      <= 1'b1;
            done_q      <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= 8'h00;
            regs_q      <= '{default: 8'h00};
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            shreg_q     <= shreg_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
        end
    end

    assign miso_o     = miso_q;
    assign hrd_data_o = regs_q[hrd_addr_i];
    assign txn_done_o = done_q;
    assign txn_wr_o   = wr_q;
    assign txn_addr_o = addr_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire
